// File: rtl/wb_writer_pkg.sv
// Shared constants and types for the register-file write-back initiator.
// Optional feature macro: WB_RETIRE_CNT_EN (see wb_writer).
package wb_writer_pkg;

    localparam int REG_BUS       = 32;
    localparam int REG_NUM_LOG2  = 5;
    localparam int WB_FIFO_DEPTH = 2;

    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Load FIFO for wb_writer: per-entry live bits, address kill and address match.
// A killed entry keeps its slot until it is popped.
module wb_fifo
    import wb_writer_pkg::*;
#(
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_NUM_LOG2,
    parameter int DEPTH  = WB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              push_live_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              kill_i,
    input  logic [ADDR_W-1:0] kill_addr_i,
    input  logic [ADDR_W-1:0] q_addr_i,
    output logic              q_busy_o,
    output logic              head_live_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]       wrPtr_q, wrPtr_d;
    logic [PW:0]       rdPtr_q, rdPtr_d;
    logic [DEPTH-1:0]  live_q, live_d;
    logic [ADDR_W-1:0] addrMem_q [DEPTH];
    logic [DATA_W-1:0] dataMem_q [DEPTH];
    logic              busy;

    assign empty_o     = (wrPtr_q == rdPtr_q);
    assign full_o      = (wrPtr_q[PW] != rdPtr_q[PW]) &&
                         (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
    assign head_live_o = live_q[rdPtr_q[PW-1:0]];
    assign head_addr_o = addrMem_q[rdPtr_q[PW-1:0]];
    assign head_data_o = dataMem_q[rdPtr_q[PW-1:0]];

    // Kill first, then pop, then push: a push always sets its own live bit.
    always_comb begin
        live_d  = live_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && live_q[i] && (addrMem_q[i] == kill_addr_i)) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop_i) begin
            live_d[rdPtr_q[PW-1:0]] = 1'b0;
            rdPtr_d                 = rdPtr_q + 1'b1;
        end
        if (push_i) begin
            live_d[wrPtr_q[PW-1:0]] = push_live_i;
            wrPtr_d                 = wrPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            live_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            live_q  <= live_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            addrMem_q[wrPtr_q[PW-1:0]] <= push_addr_i;
            dataMem_q[wrPtr_q[PW-1:0]] <= push_data_i;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addrMem_q[i] == q_addr_i)) begin
                busy = 1'b1;
            end
        end
    end

    assign q_busy_o = busy && (q_addr_i != '0);

endmodule

// File: rtl/wb_writer.sv
// Write-back initiator: merges ALU results (priority) with queued load results.
// Define WB_RETIRE_CNT_EN to add the retire_cnt output (count of cycles with we=1).
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_NUM_LOG2,
    parameter int DEPTH  = WB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_we,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_busy
`ifdef WB_RETIRE_CNT_EN
   ,output logic [31:0]       retire_cnt
`endif
);

    logic              aluReq, ldAccept, ldNonZero;
    logic              fifoPush, fifoPop, pushLive, fifoFull, fifoEmpty;
    logic              headLive;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;
    wb_src_e           src;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    assign aluReq    = alu_we && (alu_waddr != '0);
    assign ld_ready  = rst && !fifoFull;
    assign ldAccept  = ld_valid && ld_ready;
    assign ldNonZero = (ld_waddr != '0);

    always_comb begin
        src = SRC_NONE;
        if (aluReq) begin
            src = SRC_ALU;
        end else if (!fifoEmpty) begin
            src = SRC_FIFO;
        end else if (ldAccept && ldNonZero) begin
            src = SRC_BYPASS;
        end
    end

    // Loads are older than any same-cycle ALU write, so a matching load enters dead.
    assign fifoPop  = (src == SRC_FIFO);
    assign fifoPush = ldAccept && ldNonZero && (src != SRC_BYPASS);
    assign pushLive = !(aluReq && (ld_waddr == alu_waddr));

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifoPush),
        .push_live_i (pushLive),
        .push_addr_i (ld_waddr),
        .push_data_i (ld_wdata),
        .pop_i       (fifoPop),
        .kill_i      (aluReq),
        .kill_addr_i (alu_waddr),
        .q_addr_i    (q_addr),
        .q_busy_o    (q_busy),
        .head_live_o (headLive),
        .head_addr_o (headAddr),
        .head_data_o (headData),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (src)
            SRC_ALU: begin
                we_d    = 1'b1;
                waddr_d = alu_waddr;
                wdata_d = alu_wdata;
            end
            SRC_FIFO: begin
                if (headLive) begin
                    we_d    = 1'b1;
                    waddr_d = headAddr;
                    wdata_d = headData;
                end
            end
            SRC_BYPASS: begin
                we_d    = 1'b1;
                waddr_d = ld_waddr;
                wdata_d = ld_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= DATA_W'(ZERO_WORD);
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retireCnt_q <= '0;
        end else begin
            retireCnt_q <= retireCnt_q + 32'(we_q);
        end
    end

    assign retire_cnt = retireCnt_q;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer with a scoreboard of expected register-file writes.
// Builds with or without WB_RETIRE_CNT_EN.
module tb_wb_writer;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  q_addr;
    logic        q_busy;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int  checks = 0;
    int  errors = 0;
    int  writesSinceReset = 0;
    wr_t expQ[$];

    wb_writer dut (
        .clk       (clk),
        .rst       (rst),
        .alu_we    (alu_we),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_waddr  (ld_waddr),
        .ld_wdata  (ld_wdata),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .q_addr    (q_addr),
        .q_busy    (q_busy)
`ifdef WB_RETIRE_CNT_EN
       ,.retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic aWe, input logic [4:0] aAddr, input logic [31:0] aData,
                                 input logic lV, input logic [4:0] lAddr, input logic [31:0] lData);
        alu_we    = aWe;
        alu_waddr = aAddr;
        alu_wdata = aData;
        ld_valid  = lV;
        ld_waddr  = lAddr;
        ld_wdata  = lData;
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    // Every observed write is matched in order against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && we === 1'b1) begin
            writesSinceReset++;
            if (expQ.size() == 0) begin
                checkOutput("spurious_we", 64'(we), 64'd0);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("wb_addr", 64'(waddr), 64'(e.addr));
                checkOutput("wb_data", 64'(wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        q_addr = 5'd0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("rst_we", 64'(we), 64'd0);
        checkOutput("rst_waddr", 64'(waddr), 64'd0);
        checkOutput("rst_wdata", 64'(wdata), 64'd0);
        checkOutput("rst_ld_ready", 64'(ld_ready), 64'd0);
        checkOutput("rst_q_busy", 64'(q_busy), 64'd0);
        #10;
        rst = 1'b1;
        #1;
        checkOutput("ready_after_rst", 64'(ld_ready), 64'd1);

        // Load bypass with an empty FIFO.
        tick();
        applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        expectWrite(5'd5, 32'hDEADBEEF);
        #1 checkOutput("bypass_ready", 64'(ld_ready), 64'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("bypass_we", 64'(we), 64'd1);
        checkOutput("bypass_waddr", 64'(waddr), 64'd5);
        checkOutput("bypass_wdata", 64'(wdata), 64'hDEADBEEF);
        tick();
        checkOutput("bypass_idle_we", 64'(we), 64'd0);

        // ALU and load in the same cycle.
        applyStimulus(1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
        expectWrite(5'd3, 32'h1);
        expectWrite(5'd4, 32'h2);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("conflict_alu_addr", 64'(waddr), 64'd3);
        tick();
        checkOutput("conflict_ld_addr", 64'(waddr), 64'd4);
        checkOutput("conflict_ld_data", 64'(wdata), 64'h2);
        tick();

        // FIFO fills while the ALU owns the port.
        applyStimulus(1, 5'd20, 32'h20, 1, 5'd8, 32'h80);
        expectWrite(5'd20, 32'h20);
        #1 checkOutput("full_ready_1", 64'(ld_ready), 64'd1);
        tick();
        applyStimulus(1, 5'd21, 32'h21, 1, 5'd9, 32'h90);
        expectWrite(5'd21, 32'h21);
        #1 checkOutput("full_ready_2", 64'(ld_ready), 64'd1);
        tick();
        applyStimulus(1, 5'd22, 32'h22, 1, 5'd10, 32'hA0);
        expectWrite(5'd22, 32'h22);
        q_addr = 5'd8;
        #1 checkOutput("full_ready_3", 64'(ld_ready), 64'd0);
        checkOutput("full_qbusy_8", 64'(q_busy), 64'd1);
        tick();
        applyStimulus(1, 5'd23, 32'h23, 1, 5'd10, 32'hA0);
        expectWrite(5'd23, 32'h23);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd10, 32'hA0);
        expectWrite(5'd8, 32'h80);
        expectWrite(5'd9, 32'h90);
        expectWrite(5'd10, 32'hA0);
        #1 checkOutput("full_ready_pop", 64'(ld_ready), 64'd0);
        tick();
        #1 checkOutput("full_ready_again", 64'(ld_ready), 64'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("full_drained_we", 64'(we), 64'd0);

        // WAW kill of a queued load.
        applyStimulus(1, 5'd25, 32'h25, 1, 5'd7, 32'hA);
        expectWrite(5'd25, 32'h25);
        tick();
        q_addr = 5'd7;
        applyStimulus(1, 5'd7, 32'hB, 0, 0, 0);
        expectWrite(5'd7, 32'hB);
        #1 checkOutput("waw_qbusy_before", 64'(q_busy), 64'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("waw_alu_data", 64'(wdata), 64'hB);
        checkOutput("waw_qbusy_after", 64'(q_busy), 64'd0);
        tick();
        checkOutput("waw_killed_pop_we", 64'(we), 64'd0);
        tick();
        checkOutput("waw_ready", 64'(ld_ready), 64'd1);

        // Load killed in the same cycle it is accepted.
        applyStimulus(1, 5'd13, 32'hC, 1, 5'd13, 32'hD);
        expectWrite(5'd13, 32'hC);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        q_addr = 5'd13;
        #1 checkOutput("same_kill_qbusy", 64'(q_busy), 64'd0);
        tick();
        checkOutput("same_kill_pop_we", 64'(we), 64'd0);
        tick();

        // ALU to r0 is not a request; loads to r0 vanish.
        applyStimulus(1, 5'd26, 32'h26, 1, 5'd6, 32'h66);
        expectWrite(5'd26, 32'h26);
        expectWrite(5'd6, 32'h66);
        tick();
        applyStimulus(1, 5'd0, 32'hBAD, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd0, 32'h99);
        checkOutput("r0_alu_we", 64'(we), 64'd1);
        checkOutput("r0_alu_waddr", 64'(waddr), 64'd6);
        q_addr = 5'd0;
        #1 checkOutput("r0_ld_ready", 64'(ld_ready), 64'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("r0_ld_we", 64'(we), 64'd0);
        checkOutput("r0_qbusy", 64'(q_busy), 64'd0);
        tick();
        checkOutput("r0_ld_we2", 64'(we), 64'd0);
        checkOutput("r0_ready", 64'(ld_ready), 64'd1);

        // Asynchronous reset with two loads queued.
        applyStimulus(1, 5'd1, 32'h11, 1, 5'd11, 32'hB1);
        expectWrite(5'd1, 32'h11);
        tick();
        applyStimulus(1, 5'd2, 32'h22, 1, 5'd12, 32'hB2);
        expectWrite(5'd2, 32'h22);
        #1 checkOutput("rstq_ready", 64'(ld_ready), 64'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        q_addr = 5'd12;
        #1 checkOutput("rstq_full", 64'(ld_ready), 64'd0);
        checkOutput("rstq_qbusy", 64'(q_busy), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        writesSinceReset = 0;
        #1;
        checkOutput("rstq_we", 64'(we), 64'd0);
        checkOutput("rstq_ready_low", 64'(ld_ready), 64'd0);
        checkOutput("rstq_qbusy_clr", 64'(q_busy), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1 checkOutput("rstq_ready_rel", 64'(ld_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rstq_no_stale_we", 64'(we), 64'd0);
        end
        checkOutput("rstq_qbusy_rel", 64'(q_busy), 64'd0);

        tick();
        checkOutput("sb_drained", 64'(expQ.size()), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("retire_cnt", 64'(retire_cnt), 64'(writesSinceReset));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
